// File: rtl/led_sweep_gen.sv
// LED pattern sweeper: prescaled step tick drives rotate-left/right, bounce or
// hold of a WIDTH-bit pattern, with pause, pattern load and a delayed step pulse.
module led_sweep_gen #(
  parameter int unsigned       WIDTH        = 8,
  parameter int unsigned       TICK_DIV     = 8388608,
  parameter logic [WIDTH-1:0]  INIT_PATTERN = WIDTH'(8'hfc)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] led,
  output logic             step,
  output logic             dir
);

  localparam int unsigned PW = $clog2(TICK_DIV);

  localparam logic [1:0] MODE_ROL    = 2'd0;
  localparam logic [1:0] MODE_ROR    = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_HOLD   = 2'd3;

  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic             dir_q, dir_d;
  logic             pulse_q, pulse_d;
  logic             step_q, step_d;
  logic             tick;
  logic [WIDTH-1:0] rol, ror;

  assign tick = enable && (presc_q == PW'(TICK_DIV - 1));
  assign rol  = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
  assign ror  = {led_q[0], led_q[WIDTH-1:1]};

  always_comb begin
    presc_d = presc_q;
    led_d   = led_q;
    dir_d   = dir_q;
    pulse_d = 1'b0;
    step_d  = pulse_q;
    if (enable) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
    if (load) begin
      led_d   = load_data;
      presc_d = '0;
      dir_d   = (mode == MODE_ROR);
      step_d  = 1'b0;
    end else if (tick) begin
      pulse_d = (mode != MODE_HOLD);
      case (mode)
        MODE_ROL: led_d = rol;
        MODE_ROR: led_d = ror;
        MODE_BOUNCE: begin
          // End checks happen before the rotate, so a bit never wraps around.
          if ((led_q == '0) || (led_q[WIDTH-1] && led_q[0])) begin
            led_d = led_q;
          end else if (!dir_q && led_q[WIDTH-1]) begin
            dir_d = 1'b1;
            led_d = ror;
          end else if (dir_q && led_q[0]) begin
            dir_d = 1'b0;
            led_d = rol;
          end else begin
            led_d = dir_q ? ror : rol;
          end
        end
        default: led_d = led_q;
      endcase
    end
  end

  // step is delayed one edge past the led update via pulse_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      led_q   <= INIT_PATTERN;
      dir_q   <= 1'b0;
      pulse_q <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      led_q   <= led_d;
      dir_q   <= dir_d;
      pulse_q <= pulse_d;
      step_q  <= step_d;
    end
  end

  assign led  = led_q;
  assign step = step_q;
  assign dir  = dir_q;

endmodule
